// File: rtl/epmp_mem_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : epmp_mem_cycle_ctrl_pkg
//  Description : Command/state encodings and the per-state output decode
//                shared by the memory-cycle sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package epmp_mem_cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_IB_LOAD   = 2'b00,
        CMD_IB_DRIVE  = 2'b01,
        CMD_MEM_READ  = 2'b10,
        CMD_MEM_WRITE = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IBX     = 3'd1,
        S_ADDR    = 3'd2,
        S_STROBE  = 3'd3,
        S_WAIT    = 3'd4,
        S_LATCH   = 3'd5,
        S_RECOVER = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic mar_xb_en;
        logic n_rd;
        logic n_wr;
        logic mdr_xb_load;
        logic mdr_ib_load;
        logic mdr_xb_en;
        logic mdr_ib_en;
    } ctrl_out_t;

    localparam ctrl_out_t c_OUT_IDLE = '{
        busy: 1'b0, done: 1'b0, mar_xb_en: 1'b0, n_rd: 1'b1, n_wr: 1'b1,
        mdr_xb_load: 1'b0, mdr_ib_load: 1'b0, mdr_xb_en: 1'b0, mdr_ib_en: 1'b0
    };

    // Outputs that must be presented while the sequencer sits in state s.
    function automatic ctrl_out_t state_outputs(input state_t s, input cmd_t c);
        ctrl_out_t o;
        logic      is_wr;
        o     = c_OUT_IDLE;
        is_wr = (c == CMD_MEM_WRITE);
        case (s)
            S_IBX: begin
                o.busy        = 1'b1;
                o.done        = 1'b1;
                o.mdr_ib_load = (c == CMD_IB_LOAD);
                o.mdr_ib_en   = (c == CMD_IB_DRIVE);
            end
            S_ADDR: begin
                o.busy      = 1'b1;
                o.mar_xb_en = 1'b1;
                o.mdr_xb_en = is_wr;
            end
            S_STROBE, S_WAIT: begin
                o.busy      = 1'b1;
                o.mar_xb_en = 1'b1;
                o.n_rd      = is_wr;
                o.n_wr      = !is_wr;
                o.mdr_xb_en = is_wr;
            end
            S_LATCH: begin
                o.busy        = 1'b1;
                o.mar_xb_en   = 1'b1;
                o.n_rd        = 1'b0;
                o.mdr_xb_load = 1'b1;
            end
            S_RECOVER: begin
                o.busy      = 1'b1;
                o.mar_xb_en = 1'b1;
                o.mdr_xb_en = 1'b1;
            end
            S_DONE: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            default: o = c_OUT_IDLE;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/epmp_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : epmp_wait_timer
//  Description : 8-bit loadable down-counter with zero flag; times both the
//                strobe length and the ready timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module epmp_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_en,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    // Saturates at zero so a stalled enable never wraps into a long count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule
`default_nettype wire

// File: rtl/epmp_mem_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : epmp_mem_cycle_ctrl
//  Description : MDR / external-bus cycle sequencer with wait states, ready
//                handshake and timeout; all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module epmp_mem_cycle_ctrl #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic       ready,
    output logic       busy,
    output logic       done,
    output logic       bus_err,
    output logic       MAR_XB_En,
    output logic       nRD,
    output logic       nWR,
    output logic       MDR_XB_Load,
    output logic       MDR_IB_Load,
    output logic       MDR_XB_En,
    output logic       MDR_IB_En,
    output logic [2:0] Debug_State
);

    import epmp_mem_cycle_ctrl_pkg::*;

    localparam logic [7:0] c_STROBE_LOAD  = 8'(WAIT_STATES - 1);
    localparam logic [7:0] c_TIMEOUT_LOAD = 8'(TIMEOUT - 1);

    state_t    r_state;
    cmd_t      r_cmd;
    ctrl_out_t r_out;
    logic      r_bus_err;

    logic       w_tmr_load;
    logic       w_tmr_en;
    logic       w_tmr_zero;
    logic [7:0] w_tmr_val;
    cmd_t       w_cmd_in;

    assign w_cmd_in = cmd_t'(cmd);

    // The timer is reloaded on the last ADDR/STROBE cycle so it already holds
    // the right count on the first cycle of the following phase.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        w_tmr_val  = 8'd0;
        case (r_state)
            S_ADDR: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = c_STROBE_LOAD;
            end
            S_STROBE: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_TIMEOUT_LOAD;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            S_WAIT:  w_tmr_en = 1'b1;
            default: ;
        endcase
    end

    epmp_wait_timer u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= CMD_IB_LOAD;
            r_out     <= c_OUT_IDLE;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cmd     <= w_cmd_in;
                        r_bus_err <= 1'b0;
                        if (cmd[1]) begin
                            r_state <= S_ADDR;
                            r_out   <= state_outputs(S_ADDR, w_cmd_in);
                        end else begin
                            r_state <= S_IBX;
                            r_out   <= state_outputs(S_IBX, w_cmd_in);
                        end
                    end
                end
                S_IBX: begin
                    r_state <= S_IDLE;
                    r_out   <= c_OUT_IDLE;
                end
                S_ADDR: begin
                    r_state <= S_STROBE;
                    r_out   <= state_outputs(S_STROBE, r_cmd);
                end
                S_STROBE: begin
                    if (w_tmr_zero) begin
                        r_state <= S_WAIT;
                        r_out   <= state_outputs(S_WAIT, r_cmd);
                    end
                end
                S_WAIT: begin
                    // A ready seen on the final allowed cycle still completes normally.
                    if (ready) begin
                        if (r_cmd == CMD_MEM_WRITE) begin
                            r_state <= S_RECOVER;
                            r_out   <= state_outputs(S_RECOVER, r_cmd);
                        end else begin
                            r_state <= S_LATCH;
                            r_out   <= state_outputs(S_LATCH, r_cmd);
                        end
                    end else if (w_tmr_zero) begin
                        r_state   <= S_DONE;
                        r_out     <= state_outputs(S_DONE, r_cmd);
                        r_bus_err <= 1'b1;
                    end
                end
                S_LATCH, S_RECOVER: begin
                    r_state <= S_DONE;
                    r_out   <= state_outputs(S_DONE, r_cmd);
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_out   <= c_OUT_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= c_OUT_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_out.busy;
    assign done        = r_out.done;
    assign bus_err     = r_bus_err;
    assign MAR_XB_En   = r_out.mar_xb_en;
    assign nRD         = r_out.n_rd;
    assign nWR         = r_out.n_wr;
    assign MDR_XB_Load = r_out.mdr_xb_load;
    assign MDR_IB_Load = r_out.mdr_ib_load;
    assign MDR_XB_En   = r_out.mdr_xb_en;
    assign MDR_IB_En   = r_out.mdr_ib_en;
    assign Debug_State = r_state;

endmodule
`default_nettype wire

// File: tb/tb_epmp_mem_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_epmp_mem_cycle_ctrl
//  Description : Self-checking bench; expected waveforms derived per cycle
//                from the command, wait-state count and ready delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_epmp_mem_cycle_ctrl;

    localparam int WS = 2;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic       ready;
    logic       busy, done, bus_err, MAR_XB_En, nRD, nWR;
    logic       MDR_XB_Load, MDR_IB_Load, MDR_XB_En, MDR_IB_En;
    logic [2:0] Debug_State;

    int   checks   = 0;
    int   failures = 0;
    logic inv_en   = 1'b0;
    logic exp_berr = 1'b0;
    logic [2:0] idle_code;

    epmp_mem_cycle_ctrl #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .ready(ready),
        .busy(busy), .done(done), .bus_err(bus_err), .MAR_XB_En(MAR_XB_En),
        .nRD(nRD), .nWR(nWR), .MDR_XB_Load(MDR_XB_Load), .MDR_IB_Load(MDR_IB_Load),
        .MDR_XB_En(MDR_XB_En), .MDR_IB_En(MDR_IB_En), .Debug_State(Debug_State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // {busy,done,bus_err,MAR_XB_En,nRD,nWR,MDR_XB_Load,MDR_IB_Load,MDR_XB_En,MDR_IB_En}
    function automatic logic [15:0] obs_vec();
        return {6'b0, busy, done, bus_err, MAR_XB_En, nRD, nWR,
                MDR_XB_Load, MDR_IB_Load, MDR_XB_En, MDR_IB_En};
    endfunction

    function automatic logic [15:0] idle_vec(input logic berr);
        return {6'b0, 1'b0, 1'b0, berr, 1'b0, 1'b1, 1'b1, 4'b0000};
    endfunction

    // Cycle (counted from acceptance) in which done is expected.
    function automatic int done_cycle(input logic [1:0] c, input int delay);
        if (!c[1])       return 1;
        if (delay < TO)  return 3 + WS + delay + 1;
        return 2 + WS + TO;
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv_loads", {15'b0, MDR_XB_Load & MDR_IB_Load}, 16'd0);
            chk("inv_drives", {15'b0, MDR_XB_En & MDR_IB_En}, 16'd0);
            chk("inv_strobes", {15'b0, !nRD & !nWR}, 16'd0);
        end
    end

    task automatic idle_cycle();
        start = 1'b0;
        ready = 1'($urandom);
        @(negedge clk);
        chk("idle", obs_vec(), idle_vec(exp_berr));
        chk("dbg_idle", {13'b0, Debug_State}, {13'b0, idle_code});
        @(posedge clk); #1;
    endtask

    // Entered and left just after a rising edge while the DUT is idle.
    task automatic run_txn(input logic [1:0] c, input int delay);
        int   ld, k0, w;
        logic to, rd, wr;
        logic e_busy, e_done, e_mar, e_nrd, e_nwr, e_xbl, e_ibl, e_xbe, e_ibe;
        to = c[1] && (delay >= TO);
        rd = (c == 2'b10);
        wr = (c == 2'b11);
        ld = done_cycle(c, delay);
        k0 = 2 + WS;
        w  = to ? TO : delay + 1;
        start = 1'b1;
        cmd   = c;
        ready = 1'($urandom);
        @(negedge clk);
        chk("pre_accept", obs_vec(), idle_vec(exp_berr));
        for (int k = 1; k <= ld; k++) begin
            @(posedge clk); #1;
            start = 1'($urandom);
            cmd   = 2'($urandom);
            if (c[1] && k >= k0 && k < k0 + w) ready = (k - k0 >= delay);
            else                               ready = 1'($urandom);
            if (k == 1)        exp_berr = 1'b0;
            if (k == ld && to) exp_berr = 1'b1;
            e_busy = 1'b1;
            e_done = (k == ld);
            e_mar  = c[1] && (k < ld);
            e_nrd  = !(rd && k >= 2 && k <= ld - 1);
            e_nwr  = !(wr && k >= 2 && k <= (to ? ld - 1 : ld - 2));
            e_xbl  = rd && !to && (k == ld - 1);
            e_ibl  = (c == 2'b00);
            e_ibe  = (c == 2'b01);
            e_xbe  = wr && (k <= ld - 1);
            @(negedge clk);
            chk($sformatf("cmd%0d_dly%0d_cyc%0d", c, delay, k), obs_vec(),
                {6'b0, e_busy, e_done, exp_berr, e_mar, e_nrd, e_nwr,
                 e_xbl, e_ibl, e_xbe, e_ibe});
            chk("dbg_busy", {15'b0, Debug_State != idle_code}, 16'd1);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cmd   = 2'b00;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", obs_vec(), idle_vec(1'b0));
        idle_code = Debug_State;
        @(posedge clk); #1;
        rst    = 1'b0;
        inv_en = 1'b1;

        // Directed: each command type, ready boundaries and timeouts
        run_txn(2'b00, 0);
        run_txn(2'b01, 0);
        run_txn(2'b10, 0);
        run_txn(2'b11, 3);
        run_txn(2'b10, TO - 1);
        run_txn(2'b10, TO + 2);
        idle_cycle();
        run_txn(2'b00, 0);
        run_txn(2'b11, TO);
        idle_cycle();

        // Reset while idle clears the sticky error
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_berr = 1'b0;
        idle_cycle();

        // Randomized back-to-back and gapped transactions
        for (int t = 0; t < 40; t++) begin
            run_txn(2'($urandom), $urandom_range(0, TO + 1));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        // Reset during the strobe phase of a read
        start = 1'b1;
        cmd   = 2'b10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("strobe_nrd", {15'b0, nRD}, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_berr = 1'b0;
        @(negedge clk);
        chk("post_reset", obs_vec(), idle_vec(1'b0));
        @(posedge clk); #1;
        run_txn(2'b11, 0);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
